// File: rtl/block_word_feeder_if.sv
// ============================================================================
//  Module  : block_word_feeder_if
//  Brief   : Handshake and word-stream bundle for block_word_feeder.
//  Revision: 1.0
// ============================================================================
`default_nettype none

interface block_word_feeder_if #(
  parameter int WORD_W = 32,
  parameter int WORDS  = 4
);
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

  logic [WORDS*WORD_W-1:0] in_block;
  logic                    in_valid;
  logic                    in_ready;
  logic                    hold;
  logic [WORD_W-1:0]       word_out;
  logic                    set;
  logic [IDX_W-1:0]        word_idx;
  logic                    matrix_valid;
  logic                    busy;

  modport master (
    output in_block, in_valid, hold,
    input  in_ready, word_out, set, word_idx, matrix_valid, busy
  );

  modport slave (
    input  in_block, in_valid, hold,
    output in_ready, word_out, set, word_idx, matrix_valid, busy
  );
endinterface

`default_nettype wire

// File: rtl/block_word_feeder.sv
// ============================================================================
//  Module  : block_word_feeder
//  Brief   : Latches a block on handshake and streams it word 0 first with a
//            set strobe; optional abort input under FEEDER_ABORT_EN.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module block_word_feeder #(
  parameter int WORD_W = 32,
  parameter int WORDS  = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
`ifdef FEEDER_ABORT_EN
  input  logic                 abort,
`endif
  block_word_feeder_if.slave   bus
);

  localparam int                 IDX_W    = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(WORDS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FEED = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [IDX_W-1:0]  r_idx;
  logic [IDX_W-1:0]  w_idx_nxt;
  logic [WORD_W-1:0] r_blk [WORDS];
  logic              w_load;
  logic              w_abort;
  logic              w_in_ready;
  logic              w_set;
  logic              w_busy;

`ifdef FEEDER_ABORT_EN
  assign w_abort = abort;
`else
  assign w_abort = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  // Block register only moves on an accepted handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < WORDS; k++) r_blk[k] <= '0;
    end else if (w_load) begin
      for (int k = 0; k < WORDS; k++) r_blk[k] <= bus.in_block[k*WORD_W +: WORD_W];
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_load      = 1'b0;
    w_in_ready  = 1'b0;
    w_set       = 1'b0;
    w_busy      = 1'b0;
    unique case (r_state)
      ST_IDLE, ST_DONE: begin
        w_in_ready  = 1'b1;
        w_state_nxt = ST_IDLE;
        if (bus.in_valid) begin
          w_load      = 1'b1;
          w_idx_nxt   = '0;
          w_state_nxt = ST_FEED;
        end
      end
      ST_FEED: begin
        w_busy = 1'b1;
        if (w_abort) begin
          w_idx_nxt   = '0;
          w_state_nxt = ST_IDLE;
        end else if (!bus.hold) begin
          w_set = 1'b1;
          if (r_idx == LAST_IDX) begin
            w_idx_nxt   = '0;
            w_state_nxt = ST_DONE;
          end else begin
            w_idx_nxt   = r_idx + 1'b1;
          end
        end
      end
      default: begin
        w_idx_nxt   = '0;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign bus.in_ready     = w_in_ready;
  assign bus.set          = w_set;
  assign bus.busy         = w_busy;
  assign bus.word_idx     = r_idx;
  assign bus.word_out     = r_blk[r_idx];
  assign bus.matrix_valid = (r_state == ST_DONE);

endmodule

`default_nettype wire

// File: tb/tb_block_word_feeder.sv
// ============================================================================
//  Module  : tb_block_word_feeder
//  Brief   : Directed and random stimulus against a block-level stream model.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_block_word_feeder;

  localparam int WORD_W = 32;
  localparam int WORDS  = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic abort;

  block_word_feeder_if #(.WORD_W(WORD_W), .WORDS(WORDS)) bus ();

  block_word_feeder #(.WORD_W(WORD_W), .WORDS(WORDS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
`ifdef FEEDER_ABORT_EN
    .abort (abort),
`endif
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Reference: a block is either being delivered (m_active, m_sent words so far)
  // or not; m_done marks the cycle right after the last word was delivered.
  logic [WORD_W-1:0] m_words [WORDS];
  bit                m_active = 0;
  bit                m_done   = 0;
  int                m_sent   = 0;

  logic [WORD_W-1:0] stream_q [$];
  int                mv_q     [$];
  int                acc_q    [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    stream_q.delete();
    mv_q.delete();
    acc_q.delete();
  endtask

  task automatic tick(input logic v, input logic [127:0] b, input logic h, input logic a);
    bit m_set;
    bit a_eff;
    @(negedge clk);
    bus.in_valid = v;
    bus.in_block = b;
    bus.hold     = h;
    abort        = a;
    #1;
    cyc++;
`ifdef FEEDER_ABORT_EN
    a_eff = a;
`else
    a_eff = 1'b0;
`endif
    m_set = m_active && !h && !a_eff;
    chk("in_ready",     32'(bus.in_ready),     32'(!m_active));
    chk("busy",         32'(bus.busy),         32'(m_active));
    chk("set",          32'(bus.set),          32'(m_set));
    chk("matrix_valid", 32'(bus.matrix_valid), 32'(m_done));
    if (m_active) begin
      chk("word_out", bus.word_out,         m_words[m_sent]);
      chk("word_idx", 32'(bus.word_idx),    32'(m_sent));
    end
    if (bus.set)          stream_q.push_back(bus.word_out);
    if (bus.matrix_valid) mv_q.push_back(cyc);
    m_done = 0;
    if (m_active) begin
      if (a_eff) begin
        m_active = 0;
      end else if (m_set) begin
        m_sent++;
        if (m_sent == WORDS) begin
          m_active = 0;
          m_done   = 1;
        end
      end
    end else if (v) begin
      for (int k = 0; k < WORDS; k++) m_words[k] = b[k*WORD_W +: WORD_W];
      m_sent   = 0;
      m_active = 1;
      acc_q.push_back(cyc);
    end
  endtask

  task automatic chk_stream(input string tag, input logic [127:0] b);
    chk({tag, "_len"}, 32'(stream_q.size()), 32'(WORDS));
    for (int k = 0; k < WORDS; k++)
      if (k < stream_q.size()) chk({tag, "_word"}, stream_q[k], b[k*WORD_W +: WORD_W]);
  endtask

  task automatic chk_latency(input string tag, input int idx, input int exp);
    if (acc_q.size() > 0 && mv_q.size() > idx)
      chk(tag, 32'(mv_q[idx] - acc_q[0]), 32'(exp));
    else
      chk({tag, "_missing"}, 32'(mv_q.size()), 32'(idx + 1));
  endtask

  initial begin
    logic [127:0] blk_a;
    logic [127:0] blk_b;
    logic [127:0] blk_c;

    rst_n        = 1'b0;
    abort        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_block = '0;
    bus.hold     = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_in_ready", 32'(bus.in_ready),     32'd1);
    chk("rst_set",      32'(bus.set),          32'd0);
    chk("rst_busy",     32'(bus.busy),         32'd0);
    chk("rst_word_out", bus.word_out,          32'd0);
    chk("rst_mv",       32'(bus.matrix_valid), 32'd0);
    chk("rst_word_idx", 32'(bus.word_idx),     32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed: plain block, latency 5
    blk_a = 128'h33333333_22222222_11111111_00000000;
    clear_logs();
    tick(1, blk_a, 0, 0);
    repeat (6) tick(0, '0, 0, 0);
    chk_stream("t1_stream", blk_a);
    chk_latency("t1_latency", 0, 5);

    // Two stall cycles at word 1
    clear_logs();
    tick(1, blk_a, 0, 0);
    tick(0, '0, 0, 0);
    tick(0, '0, 1, 0);
    tick(0, '0, 1, 0);
    repeat (5) tick(0, '0, 0, 0);
    chk_stream("t2_stream", blk_a);
    chk_latency("t2_latency", 0, 7);

    // Back-to-back with in_valid held
    blk_b = {$urandom, $urandom, $urandom, $urandom};
    clear_logs();
    tick(1, blk_a, 0, 0);
    repeat (5) tick(1, blk_b, 0, 0);
    repeat (6) tick(0, '0, 0, 0);
    chk("t3_mv_count", 32'(mv_q.size()), 32'd2);
    chk_latency("t3_first_mv", 0, 5);
    chk_latency("t3_second_mv", 1, 10);

    // Asynchronous reset while word 2 is on the bus
    clear_logs();
    tick(1, blk_b, 0, 0);
    tick(0, '0, 0, 0);
    tick(0, '0, 0, 0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("t4_set",      32'(bus.set),          32'd0);
    chk("t4_in_ready", 32'(bus.in_ready),     32'd1);
    chk("t4_busy",     32'(bus.busy),         32'd0);
    chk("t4_mv",       32'(bus.matrix_valid), 32'd0);
    m_active = 0;
    m_done   = 0;
    m_sent   = 0;
    @(negedge clk);
    rst_n = 1'b1;
    mv_q.delete();
    repeat (6) tick(0, '0, 0, 0);
    chk("t4_no_mv", 32'(mv_q.size()), 32'd0);

`ifdef FEEDER_ABORT_EN
    // Abort at word 1 (hold also high: abort wins), then a clean block
    clear_logs();
    tick(1, blk_b, 0, 0);
    tick(0, '0, 0, 0);
    tick(0, '0, 1, 1);
    tick(0, '0, 0, 0);
    chk("t5_idle_ready", 32'(bus.in_ready), 32'd1);
    repeat (3) tick(0, '0, 0, 0);
    chk("t5_no_mv", 32'(mv_q.size()), 32'd0);
    clear_logs();
    tick(1, blk_a, 0, 0);
    repeat (6) tick(0, '0, 0, 0);
    chk_stream("t5_stream", blk_a);
    chk_latency("t5_latency", 0, 5);
`endif

    // in_valid with another block mid-stream is ignored
    blk_c = {$urandom, $urandom, $urandom, $urandom};
    clear_logs();
    tick(1, blk_b, 0, 0);
    tick(1, blk_c, 0, 0);
    tick(1, blk_c, 0, 0);
    tick(0, '0, 0, 0);
    tick(0, '0, 0, 0);
    tick(0, '0, 0, 0);
    chk_stream("t6_stream", blk_b);
    chk("t6_mv_count", 32'(mv_q.size()), 32'd1);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      tick(1'($urandom_range(0, 1)),
           {$urandom, $urandom, $urandom, $urandom},
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 9) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
